// File: rtl/fifo_async_pkg.sv
// Shared pointer helpers for the async FIFO write- and read-side controllers.
// Helpers operate on 32-bit carriers; callers truncate to their pointer width.
package fifo_async_pkg;

  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic logic [31:0] ptr_mask(input int addr_width);
    return (32'd1 << (addr_width + 1)) - 32'd1;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Occupancy between two binary pointers, modulo twice the depth.
  function automatic logic [31:0] ptr_level(input logic [31:0] wptr,
                                            input logic [31:0] rptr,
                                            input int          addr_width);
    return (wptr - rptr) & ptr_mask(addr_width);
  endfunction

  // Full: MSBs differ, lower address bits equal.
  function automatic logic ptr_full(input logic [31:0] wptr,
                                    input logic [31:0] rptr,
                                    input int          addr_width);
    return ((wptr ^ rptr) & ptr_mask(addr_width)) == (32'd1 << addr_width);
  endfunction

endpackage

// File: rtl/fifo_async_wptr_ctrl_gray2bin.sv
// Combinational Gray-to-binary converter, N bits wide.
module gray2bin #(
  parameter int N = 4
) (
  input  logic [N-1:0] gray_i,
  output logic [N-1:0] bin_o
);

  // Each binary bit is the XOR of all Gray bits at and above it.
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign bin_o[i] = ^(gray_i >> i);
  end

endmodule

// File: rtl/fifo_async_wptr_ctrl.sv
// Write-side pointer controller of the async FIFO: read-pointer synchroniser,
// write handshake, Gray pointer, full/almost-full/level flags and sticky overflow.
module fifo_async_wptr_ctrl
  import fifo_async_pkg::*;
#(
  parameter int ADDR_WIDTH   = 3,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 6
) (
  input  logic                  clk_in,
  input  logic                  nrst_in,
  input  logic                  wr_valid_in,
  output logic                  wr_ready_out,
  input  logic [ADDR_WIDTH:0]   rptr_g_async_in,
  output logic                  wen_out,
  output logic [ADDR_WIDTH-1:0] waddr_out,
  output logic [ADDR_WIDTH:0]   wptr_g_out,
  output logic                  full_out,
  output logic                  almost_full_out,
  output logic [ADDR_WIDTH:0]   wlevel_out,
  output logic                  overflow_out,
  input  logic                  clr_ovf_in
);

  localparam int PTR_W = ptr_width(ADDR_WIDTH);

  // Handshake: a write transfers on any cycle where wr_valid_in and
  // wr_ready_out are both high; wen_out is exactly that transfer.
  logic [PTR_W-1:0] wptr_b_q, wptr_b_d;
  logic [PTR_W-1:0] wptr_g_q, wptr_g_d;
  logic [PTR_W-1:0] level_q, level_d;
  logic [PTR_W-1:0] sync_q [SYNC_STAGES];
  logic [PTR_W-1:0] rptr_b_sync;
  logic             full_q, full_d;
  logic             afull_q, afull_d;
  logic             ovf_q, ovf_d;
  logic             wen;

  gray2bin #(.N(PTR_W)) u_rptr_g2b (
    .gray_i (sync_q[SYNC_STAGES-1]),
    .bin_o  (rptr_b_sync)
  );

  always_comb begin
    wen      = wr_valid_in & ~full_q;
    wptr_b_d = wptr_b_q + PTR_W'(wen);
    wptr_g_d = PTR_W'(bin2gray(32'(wptr_b_d)));
    full_d   = ptr_full(32'(wptr_b_d), 32'(rptr_b_sync), ADDR_WIDTH);
    level_d  = PTR_W'(ptr_level(32'(wptr_b_d), 32'(rptr_b_sync), ADDR_WIDTH));
    afull_d  = 32'(level_d) >= 32'(AFULL_THRESH);
    ovf_d    = ovf_q;
    // A dropped write outranks a same-cycle clear.
    if (wr_valid_in && full_q) begin
      ovf_d = 1'b1;
    end else if (clr_ovf_in) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      wptr_b_q <= '0;
      wptr_g_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      wptr_b_q <= wptr_b_d;
      wptr_g_q <= wptr_g_d;
      level_q  <= level_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
      sync_q[0] <= rptr_g_async_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign wen_out         = wen;
  assign wr_ready_out    = ~full_q;
  assign waddr_out       = wptr_b_q[ADDR_WIDTH-1:0];
  assign wptr_g_out      = wptr_g_q;
  assign full_out        = full_q;
  assign almost_full_out = afull_q;
  assign wlevel_out      = level_q;
  assign overflow_out    = ovf_q;

endmodule

// File: tb/tb_fifo_async_wptr_ctrl.sv
// Bench for fifo_async_wptr_ctrl: directed scenarios plus randomized traffic
// checked against an occupancy-arithmetic reference model.
module tb_fifo_async_wptr_ctrl;

  logic       clk_in = 1'b0;
  logic       nrst_in = 1'b0;
  logic       wr_valid_in = 1'b0;
  logic       wr_ready_out;
  logic [3:0] rptr_g_async_in = '0;
  logic       wen_out;
  logic [2:0] waddr_out;
  logic [3:0] wptr_g_out;
  logic       full_out;
  logic       almost_full_out;
  logic [3:0] wlevel_out;
  logic       overflow_out;
  logic       clr_ovf_in = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model: pointer count mod 16, flags derived from occupancy.
  int   m_w;
  int   m_level;
  logic m_full;
  logic m_ovf;
  int   rq[$];

  fifo_async_wptr_ctrl #(
    .ADDR_WIDTH(3), .SYNC_STAGES(2), .AFULL_THRESH(6)
  ) dut (
    .clk_in          (clk_in),
    .nrst_in         (nrst_in),
    .wr_valid_in     (wr_valid_in),
    .wr_ready_out    (wr_ready_out),
    .rptr_g_async_in (rptr_g_async_in),
    .wen_out         (wen_out),
    .waddr_out       (waddr_out),
    .wptr_g_out      (wptr_g_out),
    .full_out        (full_out),
    .almost_full_out (almost_full_out),
    .wlevel_out      (wlevel_out),
    .overflow_out    (overflow_out),
    .clr_ovf_in      (clr_ovf_in)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [3:0] to_gray(input int b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic model_reset();
    m_w = 0; m_level = 0; m_full = 1'b0; m_ovf = 1'b0;
    rq = {0, 0};
  endtask

  // One write-domain cycle: drive at negedge, check combinational outputs,
  // advance the model at the edge, check registered outputs after it.
  task automatic cycle(input logic v, input logic c, input int rbin);
    int   rs;
    logic acc;
    wr_valid_in = v;
    clr_ovf_in = c;
    rptr_g_async_in = to_gray(rbin);
    #1;
    acc = v && !m_full;
    checks++;
    if (wen_out !== acc) begin
      errors++; $display("FAIL wen_out got %0b exp %0b", wen_out, acc);
    end
    checks++;
    if (wr_ready_out !== !m_full) begin
      errors++; $display("FAIL wr_ready_out got %0b exp %0b", wr_ready_out, !m_full);
    end
    checks++;
    if (waddr_out !== 3'(m_w % 8)) begin
      errors++; $display("FAIL waddr_out got %0d exp %0d", waddr_out, m_w % 8);
    end
    @(posedge clk_in);
    rs = rq.pop_front();
    rq.push_back(rbin);
    if (v && m_full) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    m_w = (m_w + (acc ? 1 : 0)) % 16;
    m_level = (m_w - rs + 16) % 16;
    m_full = (m_level == 8);
    #1;
    checks++;
    if (wptr_g_out !== to_gray(m_w)) begin
      errors++; $display("FAIL wptr_g_out got %0d exp %0d", wptr_g_out, to_gray(m_w));
    end
    checks++;
    if (wlevel_out !== 4'(m_level)) begin
      errors++; $display("FAIL wlevel_out got %0d exp %0d", wlevel_out, m_level);
    end
    checks++;
    if (full_out !== m_full) begin
      errors++; $display("FAIL full_out got %0b exp %0b", full_out, m_full);
    end
    checks++;
    if (almost_full_out !== (m_level >= 6)) begin
      errors++; $display("FAIL almost_full_out got %0b exp %0b", almost_full_out, m_level >= 6);
    end
    checks++;
    if (overflow_out !== m_ovf) begin
      errors++; $display("FAIL overflow_out got %0b exp %0b", overflow_out, m_ovf);
    end
    @(negedge clk_in);
  endtask

  task automatic test_reset();
    @(negedge clk_in);
    wr_valid_in = 1'b0; clr_ovf_in = 1'b0; rptr_g_async_in = '0;
    #2 nrst_in = 1'b0;
    #1;
    checks++;
    if ({wptr_g_out, waddr_out, full_out, almost_full_out, wlevel_out, overflow_out} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got g=%0d a=%0d f=%0b af=%0b l=%0d o=%0b exp all 0",
               wptr_g_out, waddr_out, full_out, almost_full_out, wlevel_out, overflow_out);
    end
    checks++;
    if (wr_ready_out !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %0b exp 1", wr_ready_out);
    end
    model_reset();
    @(negedge clk_in);
    nrst_in = 1'b1;
  endtask

  task automatic test_fill();
    logic [3:0] exp_g [8] = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12};
    test_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, 0);
      checks++;
      if (wptr_g_out !== exp_g[i]) begin
        errors++; $display("FAIL fill_gray[%0d] got %0d exp %0d", i, wptr_g_out, exp_g[i]);
      end
      checks++;
      if (almost_full_out !== (i + 1 >= 6)) begin
        errors++; $display("FAIL fill_afull[%0d] got %0b exp %0b", i, almost_full_out, i + 1 >= 6);
      end
    end
    checks++;
    if (full_out !== 1'b1 || wlevel_out !== 4'd8 || wr_ready_out !== 1'b0) begin
      errors++;
      $display("FAIL fill_full got f=%0b l=%0d r=%0b exp f=1 l=8 r=0",
               full_out, wlevel_out, wr_ready_out);
    end
  endtask

  task automatic test_overflow();
    cycle(1'b1, 1'b0, 0);
    checks++;
    if (overflow_out !== 1'b1 || wptr_g_out !== 4'd12) begin
      errors++; $display("FAIL ovf_set got o=%0b g=%0d exp o=1 g=12", overflow_out, wptr_g_out);
    end
    cycle(1'b0, 1'b1, 0);
    checks++;
    if (overflow_out !== 1'b0) begin
      errors++; $display("FAIL ovf_clear got %0b exp 0", overflow_out);
    end
    cycle(1'b1, 1'b1, 0);
    checks++;
    if (overflow_out !== 1'b1) begin
      errors++; $display("FAIL ovf_set_wins got %0b exp 1", overflow_out);
    end
    cycle(1'b0, 1'b1, 0);
  endtask

  task automatic test_drain_visibility();
    int edges = 0;
    bit seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle(1'b0, 1'b0, 3);
      edges++;
      if (!full_out) seen = 1;
    end
    checks++;
    if (!seen || edges != 3) begin
      errors++; $display("FAIL drain_latency got %0d edges (seen=%0b) exp 3", edges, seen);
    end
    checks++;
    if (wlevel_out !== 4'd5 || almost_full_out !== 1'b0) begin
      errors++;
      $display("FAIL drain_level got l=%0d af=%0b exp l=5 af=0", wlevel_out, almost_full_out);
    end
  endtask

  task automatic test_wrap();
    test_reset();
    for (int n = 0; n < 20; n++) begin
      cycle(1'b1, 1'b0, (n >= 2) ? (n - 2) % 16 : 0);
      checks++;
      if (full_out !== 1'b0 || wlevel_out > 4'd5) begin
        errors++; $display("FAIL wrap_bound[%0d] got f=%0b l=%0d exp f=0 l<=5", n, full_out, wlevel_out);
      end
      if (n == 15) begin
        checks++;
        if (wptr_g_out !== 4'd0) begin
          errors++; $display("FAIL wrap_gray_zero got %0d exp 0", wptr_g_out);
        end
      end
    end
  endtask

  task automatic test_reset_mid_fill();
    test_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 0);
    checks++;
    if (wlevel_out !== 4'd5) begin
      errors++; $display("FAIL midfill_level got %0d exp 5", wlevel_out);
    end
    test_reset();
    cycle(1'b1, 1'b0, 0);
    checks++;
    if (waddr_out !== 3'd1) begin
      errors++; $display("FAIL midfill_next_addr got %0d exp 1", waddr_out);
    end
  endtask

  task automatic test_random();
    int r = 0;
    test_reset();
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, r);
      if (r != m_w && $urandom_range(0, 2) == 0) r = (r + 1) % 16;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill();
    test_overflow();
    test_drain_visibility();
    test_wrap();
    test_reset_mid_fill();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
